// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared constants and types for the PS/2 key event tracker.
//
// Contents:
//   PS2_* byte constants  - scancode prefixes and controller status bytes.
//   parser_state_e        - prefix parser states.
//   key_event_t           - one FIFO entry {ext, code, brk[, tstamp]}.
//   KEY_EVENT_W           - bit width of key_event_t.
//   is_status_byte()      - bytes that IDLE silently ignores.
//
// Optional feature: define KEY_EVENT_TIMESTAMP_EN to add a 16-bit tstamp field
// to every event.
package ps2_key_pkg;

    localparam logic [7:0] PS2_EXTEND     = 8'hE0;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_BAT        = 8'hAA;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_ECHO       = 8'hEE;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StSkip
    } parser_state_e;

    typedef struct packed {
`ifdef KEY_EVENT_TIMESTAMP_EN
        logic [15:0] tstamp;
`endif
        logic        ext;
        logic [7:0]  code;
        logic        brk;
    } key_event_t;

    localparam int unsigned KEY_EVENT_W = $bits(key_event_t);

    // Controller replies and error bytes that carry no key information.
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ECHO) ||
               (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_event_tracker_if.sv
// ps2_key_event_tracker_if: scancode input and event output handshake bundle.
//
// Signals:
//   rx_data[7:0], rx_valid  - scancode byte strobe from the keyboard controller.
//   ev_valid, ev_ready      - event FIFO head handshake.
//   ev_code[8:0], ev_break  - head event {ext, code} and release flag.
//   ev_count                - FIFO occupancy.
//   ev_time[15:0]           - head timestamp (KEY_EVENT_TIMESTAMP_EN only).
//
// Modports: master is the tracker (consumes bytes, produces events);
// slave is the controller/consumer side.
interface ps2_key_event_tracker_if #(
    parameter int unsigned FIFO_DEPTH = 8
) ();

    logic [7:0]                  rx_data;
    logic                        rx_valid;
    logic                        ev_valid;
    logic                        ev_ready;
    logic [8:0]                  ev_code;
    logic                        ev_break;
    logic [$clog2(FIFO_DEPTH):0] ev_count;

`ifdef KEY_EVENT_TIMESTAMP_EN
    logic [15:0]                 ev_time;

    modport master (
        input  rx_data, rx_valid, ev_ready,
        output ev_valid, ev_code, ev_break, ev_count, ev_time
    );

    modport slave (
        output rx_data, rx_valid, ev_ready,
        input  ev_valid, ev_code, ev_break, ev_count, ev_time
    );
`else
    modport master (
        input  rx_data, rx_valid, ev_ready,
        output ev_valid, ev_code, ev_break, ev_count
    );

    modport slave (
        output rx_data, rx_valid, ev_ready,
        input  ev_valid, ev_code, ev_break, ev_count
    );
`endif

endinterface

// File: rtl/key_event_fifo.sv
// key_event_fifo: synchronous show-ahead FIFO.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset.
//   push, wr_data   - write request and data; dropped when full unless popping.
//   pop             - remove the head; ignored when empty.
//   rd_data         - current head (valid while !empty).
//   full, empty     - occupancy flags.
//   count           - occupancy, 0..DEPTH.
//
// DEPTH must be a power of two so the pointers wrap naturally.
module key_event_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_tracker.sv
// ps2_key_event_tracker: PS/2 scancode parser, pressed-key map and event queue.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset.
//   bus           - ps2_key_event_tracker_if.master: scancode strobe in,
//                   make/break events out through a valid/ready FIFO.
//   key_down[511:0] - bit {ext, code} set while that key is held.
//   overflow      - sticky, an event was dropped on a full FIFO.
//   overflow_clr  - clears overflow (a same-cycle drop wins).
//   bat_seen      - one-cycle pulse for an AA self-test byte in IDLE.
//
// Timing: final byte strobed in cycle N -> key_down in N+1, event at head in N+2.
// Optional feature: define KEY_EVENT_TIMESTAMP_EN to add bus.ev_time, a
// cycle/1024 tick captured when each event enters the FIFO.
module ps2_key_event_tracker
    import ps2_key_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_REPEAT  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned PAUSE_SKIP     = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_key_event_tracker_if.master bus,
    output logic [511:0]            key_down,
    output logic                    overflow,
    input  logic                    overflow_clr,
    output logic                    bat_seen
);

    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned SKIP_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        rx_data;
    logic              rx_valid;
    parser_state_e     state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    // Decoded result of the byte presented this cycle.
    logic              make_evt;
    logic              brk_evt;
    logic              evt_ext;
    logic              bat_evt;
    logic [8:0]        evt_idx;

    logic [511:0]      key_down_q;
    logic              bat_q;
    logic              overflow_q;

    // Event waiting one cycle before entering the FIFO.
    logic              pend_push_q;
    logic              pend_ext_q;
    logic [7:0]        pend_code_q;
    logic              pend_brk_q;

    key_event_t              wr_entry;
    key_event_t              rd_entry;
    logic [KEY_EVENT_W-1:0]  rd_bits;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [CNT_W-1:0]        fifo_count;

    assign rx_data  = bus.rx_data;
    assign rx_valid = bus.rx_valid;
    assign evt_idx  = {evt_ext, rx_data};

    // ---------------------------------------------------------------- parser

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            skip_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = '0;
        if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == PS2_EXTEND) begin
                        state_d = StExt;
                    end else if (rx_data == PS2_BREAK) begin
                        state_d = StBrk;
                    end else if (rx_data == PS2_PAUSE) begin
                        skip_d  = SKIP_W'(PAUSE_SKIP);
                        state_d = (PAUSE_SKIP == 0) ? StIdle : StSkip;
                    end
                end
                StExt: begin
                    if (rx_data == PS2_BREAK) begin
                        state_d = StExtBrk;
                    end else if (rx_data != PS2_EXTEND) begin
                        state_d = StIdle;
                    end
                end
                StBrk, StExtBrk: state_d = StIdle;
                StSkip: begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q == SKIP_W'(1)) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            // Abandon a half-received sequence after a long silence.
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_comb begin
        make_evt = 1'b0;
        brk_evt  = 1'b0;
        evt_ext  = 1'b0;
        bat_evt  = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == PS2_BAT) begin
                        bat_evt = 1'b1;
                    end else if (rx_data != PS2_EXTEND && rx_data != PS2_BREAK &&
                                 rx_data != PS2_PAUSE && !is_status_byte(rx_data)) begin
                        make_evt = 1'b1;
                    end
                end
                StExt: begin
                    if (rx_data != PS2_BREAK && rx_data != PS2_EXTEND &&
                        rx_data != PS2_FAKE_SHIFT) begin
                        make_evt = 1'b1;
                        evt_ext  = 1'b1;
                    end
                end
                StBrk: brk_evt = 1'b1;
                StExtBrk: begin
                    if (rx_data != PS2_FAKE_SHIFT) begin
                        brk_evt = 1'b1;
                        evt_ext = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------ key map / events

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_down_q  <= '0;
            bat_q       <= 1'b0;
            pend_push_q <= 1'b0;
            pend_ext_q  <= 1'b0;
            pend_code_q <= '0;
            pend_brk_q  <= 1'b0;
        end else begin
            bat_q       <= bat_evt;
            pend_push_q <= 1'b0;
            pend_ext_q  <= evt_ext;
            pend_code_q <= rx_data;
            pend_brk_q  <= brk_evt;
            if (bat_evt) begin
                key_down_q <= '0;
            end else if (make_evt) begin
                key_down_q[evt_idx] <= 1'b1;
                pend_push_q <= (FILTER_REPEAT == 0) || !key_down_q[evt_idx];
            end else if (brk_evt) begin
                key_down_q[evt_idx] <= 1'b0;
                pend_push_q <= (FILTER_REPEAT == 0) || key_down_q[evt_idx];
            end
        end
    end

`ifdef KEY_EVENT_TIMESTAMP_EN
    logic [9:0]  prescale_q;
    logic [15:0] tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            tick_q     <= '0;
        end else begin
            prescale_q <= prescale_q + 10'd1;
            if (prescale_q == 10'h3FF) begin
                tick_q <= tick_q + 16'd1;
            end
        end
    end

    always_comb begin
        wr_entry        = '0;
        wr_entry.tstamp = tick_q;
        wr_entry.ext    = pend_ext_q;
        wr_entry.code   = pend_code_q;
        wr_entry.brk    = pend_brk_q;
    end

    assign bus.ev_time = rd_entry.tstamp;
`else
    always_comb begin
        wr_entry      = '0;
        wr_entry.ext  = pend_ext_q;
        wr_entry.code = pend_code_q;
        wr_entry.brk  = pend_brk_q;
    end
`endif

    // ---------------------------------------------------------------- FIFO

    assign fifo_pop = !fifo_empty && bus.ev_ready;

    key_event_fifo #(
        .WIDTH (KEY_EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (pend_push_q),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (rd_bits),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_entry = key_event_t'(rd_bits);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (pend_push_q && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.ev_valid = !fifo_empty;
    assign bus.ev_code  = {rd_entry.ext, rd_entry.code};
    assign bus.ev_break = rd_entry.brk;
    assign bus.ev_count = fifo_count;
    assign key_down     = key_down_q;
    assign overflow     = overflow_q;
    assign bat_seen     = bat_q;

endmodule
